// File: rtl/result_uart_tx.sv
// Captures a p_N-bit result and sends it as uppercase ASCII hex plus CR LF over 8N1 UART.
// Acceptance drops txd on the accept edge; requests while busy are ignored.
module result_uart_tx #(
  parameter int clk_freq       = 50000000,
  parameter int uart_baud_rate = 57600,
  parameter int p_N            = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [p_N-1:0] i_data,
  input  logic           i_send,
  output logic           o_busy,
  output logic           o_done,
  output logic           uart_txd
);

  localparam int DIV = clk_freq / uart_baud_rate;
  localparam int ND  = p_N / 4;
  localparam int BW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(ND + 2);

  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [CW-1:0] CHAR_CR   = CW'(ND);
  localparam logic [CW-1:0] CHAR_LAST = CW'(ND + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  if (DIV < 2 || (p_N % 4) != 0) begin : g_bad_param
    $error("result_uart_tx: illegal parameters (DIV=%0d, p_N=%0d)", DIV, p_N);
  end

  logic [1:0]     state;
  logic [BW-1:0]  baud_cnt;
  logic [2:0]     bit_idx;
  logic [CW-1:0]  char_idx;
  logic [p_N-1:0] shadow;
  logic [3:0]     nib;
  logic [7:0]     char_byte;

  // Character under transmission: hex digits MSB nibble first, then CR, then LF.
  always_comb begin
    nib = 4'h0;
    for (int i = 0; i < ND; i++) begin
      if (char_idx == CW'(i)) nib = shadow[(ND-1-i)*4 +: 4];
    end
    if (char_idx < CHAR_CR)
      char_byte = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    else if (char_idx == CHAR_CR)
      char_byte = 8'h0D;
    else
      char_byte = 8'h0A;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
      shadow   <= '0;
      uart_txd <= 1'b1;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (state == S_IDLE) begin
        if (i_send) begin
          shadow   <= i_data;
          state    <= S_START;
          o_busy   <= 1'b1;
          uart_txd <= 1'b0;
          baud_cnt <= '0;
          bit_idx  <= '0;
          char_idx <= '0;
        end
      end else if (baud_cnt != BAUD_LAST) begin
        baud_cnt <= baud_cnt + 1'b1;
      end else begin
        // Bit boundary: txd is loaded with the next bit on this edge.
        baud_cnt <= '0;
        case (state)
          S_START: begin
            state    <= S_DATA;
            bit_idx  <= '0;
            uart_txd <= char_byte[0];
          end
          S_DATA: begin
            if (bit_idx == 3'd7) begin
              state    <= S_STOP;
              uart_txd <= 1'b1;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              uart_txd <= char_byte[3'(bit_idx + 3'd1)];
            end
          end
          S_STOP: begin
            if (char_idx == CHAR_LAST) begin
              state    <= S_IDLE;
              char_idx <= '0;
              o_busy   <= 1'b0;
              o_done   <= 1'b1;
            end else begin
              char_idx <= char_idx + 1'b1;
              state    <= S_START;
              uart_txd <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx with DIV=10; a UART decoder pops expected bytes from a scoreboard queue.
module tb_result_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_data;
  logic        i_send;
  logic        o_busy, o_done, uart_txd;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int busy_cyc  = 0;
  int done_cnt  = 0;
  bit rx_abort  = 1'b0;
  logic [7:0] exp_q[$];

  result_uart_tx #(.clk_freq(1000), .uart_baud_rate(100), .p_N(16)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_send(i_send),
    .o_busy(o_busy), .o_done(o_done), .uart_txd(uart_txd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (o_busy === 1'b1) busy_cyc++;
    if (o_done === 1'b1) done_cnt++;
  end

  // Decoder: bit k centre lies 10*k+5 falling edges after the start-bit detection.
  initial begin : monitor
    logic [7:0] rx;
    logic       stop_bit;
    forever begin
      @(negedge clk);
      if (uart_txd === 1'b0) begin
        repeat (5) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (10) @(negedge clk);
          rx[k] = uart_txd;
        end
        repeat (10) @(negedge clk);
        stop_bit = uart_txd;
        if (rx_abort) begin
          rx_abort = 1'b0;
        end else begin
          chk("rx_stop_bit", 32'(stop_bit), 32'd1);
          if (exp_q.size() == 0) chk("rx_unexpected_byte", 32'(rx), 32'hFFFF_FFFF);
          else chk("rx_byte", 32'(rx), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic push6(input logic [7:0] b0, b1, b2, b3, b4, b5);
    exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2);
    exp_q.push_back(b3); exp_q.push_back(b4); exp_q.push_back(b5);
  endtask

  // Issue a one-cycle request and confirm it is accepted on that edge.
  task automatic send(input logic [15:0] d);
    @(negedge clk);
    i_data = d;
    i_send = 1'b1;
    @(posedge clk); #1;
    chk("accept_txd_low", 32'(uart_txd), 32'd0);
    chk("accept_busy", 32'(o_busy), 32'd1);
    @(negedge clk);
    i_send = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (o_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("done_timeout", 32'(n), 32'(budget - 1));
  endtask

  task automatic run_msg(input logic [15:0] d, input string name);
    busy_cyc = 0;
    done_cnt = 0;
    send(d);
    wait_done(800);
    repeat (20) @(negedge clk);
    chk({name, "_busy_cycles"}, 32'(busy_cyc), 32'd600);
    chk({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst    = 1'b0;
    i_send = 1'b1;
    i_data = 16'h1234;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_txd", 32'(uart_txd), 32'd1);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_done", 32'(o_done), 32'd0);
    end
    rst    = 1'b1;
    i_send = 1'b0;
    busy_cyc = 0;
    repeat (50) @(negedge clk);
    chk("post_rst_idle_busy", 32'(busy_cyc), 32'd0);
    chk("post_rst_idle_txd", 32'(uart_txd), 32'd1);

    push6(8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A);
    run_msg(16'h1234, "msg_1234");
    push6(8'h41, 8'h42, 8'h43, 8'h46, 8'h0D, 8'h0A);
    run_msg(16'hABCF, "msg_abcf");
    push6(8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A);
    run_msg(16'h0000, "msg_0000");

    // Request and data change while busy must not disturb the message.
    push6(8'h30, 8'h30, 8'h46, 8'h46, 8'h0D, 8'h0A);
    busy_cyc = 0;
    done_cnt = 0;
    send(16'h00FF);
    repeat (98) @(negedge clk);
    i_data = 16'h1111;
    i_send = 1'b1;
    @(negedge clk);
    i_send = 1'b0;
    wait_done(800);
    repeat (700) @(negedge clk);
    chk("busy_ign_busy_cycles", 32'(busy_cyc), 32'd600);
    chk("busy_ign_done_pulses", 32'(done_cnt), 32'd1);

    // Reset during char 2 data bits; only chars 0 and 1 complete.
    exp_q.push_back(8'h39);
    exp_q.push_back(8'h44);
    busy_cyc = 0;
    done_cnt = 0;
    send(16'h9D2B);
    repeat (238) @(negedge clk);
    rst = 1'b0;
    rx_abort = 1'b1;
    @(posedge clk); #1;
    chk("midrst_txd", 32'(uart_txd), 32'd1);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_done", 32'(o_done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (200) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    chk("midrst_idle_txd", 32'(uart_txd), 32'd1);
    chk("midrst_idle_busy", 32'(o_busy), 32'd0);
    push6(8'h39, 8'h44, 8'h32, 8'h42, 8'h0D, 8'h0A);
    run_msg(16'h9D2B, "msg_after_rst");

    // Back-to-back: second request lands in the o_done cycle.
    push6(8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A);
    busy_cyc = 0;
    done_cnt = 0;
    send(16'h1234);
    wait_done(800);
    chk("b2b_busy_low_in_done", 32'(o_busy), 32'd0);
    push6(8'h35, 8'h41, 8'h35, 8'h41, 8'h0D, 8'h0A);
    i_data = 16'h5A5A;
    i_send = 1'b1;
    @(posedge clk); #1;
    chk("b2b_accept_txd_low", 32'(uart_txd), 32'd0);
    chk("b2b_accept_busy", 32'(o_busy), 32'd1);
    @(negedge clk);
    i_send = 1'b0;
    wait_done(800);
    repeat (20) @(negedge clk);
    chk("b2b_busy_cycles", 32'(busy_cyc), 32'd1200);
    chk("b2b_done_pulses", 32'(done_cnt), 32'd2);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
